// File: rtl/reg_dest_demux_pkg.sv
// Shared constants for the register-destination demultiplexer.
// Optional feature macro: DEMUX_STATS_EN (per-channel drain counters).
package reg_dest_demux_pkg;

   localparam int unsigned DATA_W_DEFAULT = 5;
   localparam int unsigned NUM_CH         = 4;
   localparam int unsigned SEL_W          = 2;
   localparam int unsigned CNT_W          = 8;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/demux_slot.sv
// One channel of the demultiplexer: a single-entry holding slot with
// full flag and data register. Load and drain in the same cycle keep the
// slot full with the new payload, so each channel sustains one per cycle.
// Optional feature macro: DEMUX_STATS_EN adds a saturating drain counter.
module demux_slot
   import reg_dest_demux_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              ready_i,
`ifdef DEMUX_STATS_EN
   output logic [CNT_W-1:0]  count_o,
`endif
   output logic              full_o,
   output logic [DATA_W-1:0] data_o
);

   logic              full_q, full_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              drain;

   // Next-state for the slot: load wins over drain, otherwise drain empties it.
   always_comb begin
      drain  = full_q & ready_i;
      full_d = load_i | (full_q & ~drain);
      data_d = load_i ? data_i : data_q;
   end

   // Slot state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

   assign full_o = full_q;
   assign data_o = data_q;

`ifdef DEMUX_STATS_EN
   logic [CNT_W-1:0] count_q, count_d;

   // Count drains, sticking at the maximum value.
   always_comb begin
      count_d = count_q;
      if (drain && (count_q != CNT_MAX)) begin
         count_d = count_q + 1'b1;
      end
   end

   // Drain counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
`endif

endmodule

// File: rtl/reg_dest_demux.sv
// Register-destination demultiplexer: routes one input payload to one of
// four single-entry channel slots chosen by in_sel.
// Optional feature macro: DEMUX_STATS_EN exposes per-channel drain counts.
module reg_dest_demux
   import reg_dest_demux_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [SEL_W-1:0]  in_sel,
   output logic [NUM_CH-1:0] out_valid,
   input  logic [NUM_CH-1:0] out_ready,
`ifdef DEMUX_STATS_EN
   output logic [CNT_W-1:0]  ch_count_0,
   output logic [CNT_W-1:0]  ch_count_1,
   output logic [CNT_W-1:0]  ch_count_2,
   output logic [CNT_W-1:0]  ch_count_3,
`endif
   output logic [DATA_W-1:0] out_data_0,
   output logic [DATA_W-1:0] out_data_1,
   output logic [DATA_W-1:0] out_data_2,
   output logic [DATA_W-1:0] out_data_3
);

   logic [NUM_CH-1:0] full;
   logic [NUM_CH-1:0] sel_oh;
   logic [NUM_CH-1:0] load;
   logic              accept;
   logic [DATA_W-1:0] slot_data [NUM_CH];

   // Select decode and ready generation; ready ignores in_valid on purpose.
   always_comb begin
      sel_oh         = '0;
      sel_oh[in_sel] = 1'b1;
      in_ready       = ~full[in_sel] | out_ready[in_sel];
      accept         = in_valid & in_ready;
      load           = accept ? sel_oh : '0;
   end

`ifdef DEMUX_STATS_EN
   logic [CNT_W-1:0] slot_count [NUM_CH];
`endif

   for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
      demux_slot #(
         .DATA_W (DATA_W)
      ) u_slot (
         .clk_i   (clk),
         .rst_ni  (rst_n),
         .load_i  (load[k]),
         .data_i  (in_data),
         .ready_i (out_ready[k]),
`ifdef DEMUX_STATS_EN
         .count_o (slot_count[k]),
`endif
         .full_o  (full[k]),
         .data_o  (slot_data[k])
      );
   end

   assign out_valid  = full;
   assign out_data_0 = slot_data[0];
   assign out_data_1 = slot_data[1];
   assign out_data_2 = slot_data[2];
   assign out_data_3 = slot_data[3];

`ifdef DEMUX_STATS_EN
   assign ch_count_0 = slot_count[0];
   assign ch_count_1 = slot_count[1];
   assign ch_count_2 = slot_count[2];
   assign ch_count_3 = slot_count[3];
`endif

endmodule

// File: tb/tb_reg_dest_demux.sv
// Directed self-checking bench for reg_dest_demux.
// Counter checks are compiled in when DEMUX_STATS_EN is defined.
module tb_reg_dest_demux;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [4:0] in_data;
   logic [1:0] in_sel;
   logic [3:0] out_valid;
   logic [3:0] out_ready;
   logic [4:0] out_data_0, out_data_1, out_data_2, out_data_3;
`ifdef DEMUX_STATS_EN
   logic [7:0] ch_count_0, ch_count_1, ch_count_2, ch_count_3;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   reg_dest_demux #(
      .DATA_W (5)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
`ifdef DEMUX_STATS_EN
      .ch_count_0 (ch_count_0),
      .ch_count_1 (ch_count_1),
      .ch_count_2 (ch_count_2),
      .ch_count_3 (ch_count_3),
`endif
      .out_data_0 (out_data_0),
      .out_data_1 (out_data_1),
      .out_data_2 (out_data_2),
      .out_data_3 (out_data_3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle past the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] sel, input logic [4:0] data);
      in_valid = 1'b1;
      in_sel   = sel;
      in_data  = data;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      in_valid  = 1'b0;
      in_data   = '0;
      in_sel    = '0;
      out_ready = '0;
      rst_n     = 1'b0;
      #2;
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_data2", 32'(out_data_2), 32'd0);
      tick();
      tick();
      #2 rst_n = 1'b1;
      tick();

      // Idle: ready for every destination
      for (int s = 0; s < 4; s++) begin
         in_sel = 2'(s);
         #1;
         check($sformatf("idle_in_ready_sel%0d", s), 32'(in_ready), 32'd1);
      end
      check("idle_out_valid", 32'(out_valid), 32'd0);
`ifdef DEMUX_STATS_EN
      check("idle_count0", 32'(ch_count_0), 32'd0);
      check("idle_count3", 32'(ch_count_3), 32'd0);
`endif

      // Single payload to ch2 with no downstream ready
      send(2'd2, 5'd17);
      check("ch2_out_valid", 32'(out_valid), 32'b0100);
      check("ch2_out_data", 32'(out_data_2), 32'd17);
      in_sel = 2'd2;
      #1;
      check("ch2_full_in_ready", 32'(in_ready), 32'd0);
      in_sel = 2'd0;
      #1;
      check("ch0_in_ready", 32'(in_ready), 32'd1);

      // in_valid low: sel/data ignored, held data stable under backpressure
      in_sel  = 2'd2;
      in_data = 5'd30;
      tick();
      check("ignore_out_valid", 32'(out_valid), 32'b0100);
      check("hold_data2", 32'(out_data_2), 32'd17);

      // Streaming 1..8 into ch2 while it drains every cycle
      out_ready = 4'b0100;
      in_valid  = 1'b1;
      in_sel    = 2'd2;
      for (int i = 1; i <= 8; i++) begin
         in_data = 5'(i);
         #1;
         check($sformatf("stream_in_ready_%0d", i), 32'(in_ready), 32'd1);
         tick();
         check($sformatf("stream_valid_%0d", i), 32'(out_valid), 32'b0100);
         check($sformatf("stream_data_%0d", i), 32'(out_data_2), 32'(i));
      end
      in_valid = 1'b0;
      tick();
      check("stream_drained", 32'(out_valid), 32'd0);
`ifdef DEMUX_STATS_EN
      check("stream_count2", 32'(ch_count_2), 32'd9);
      check("stream_count0", 32'(ch_count_0), 32'd0);
`endif

      // Fill all channels, then drain all at once
      out_ready = 4'b0000;
      send(2'd0, 5'd3);
      send(2'd1, 5'd7);
      send(2'd2, 5'd11);
      send(2'd3, 5'd31);
      check("fill_out_valid", 32'(out_valid), 32'b1111);
      check("fill_data0", 32'(out_data_0), 32'd3);
      check("fill_data1", 32'(out_data_1), 32'd7);
      check("fill_data2", 32'(out_data_2), 32'd11);
      check("fill_data3", 32'(out_data_3), 32'd31);
      out_ready = 4'b1111;
      tick();
      check("drain_all_valid", 32'(out_valid), 32'd0);

      // Asynchronous reset while ch1 holds a payload
      out_ready = 4'b0000;
      send(2'd1, 5'd9);
      check("pre_reset_valid", 32'(out_valid), 32'b0010);
      check("pre_reset_data1", 32'(out_data_1), 32'd9);
      #3 rst_n = 1'b0;
      #1;
      check("async_reset_valid", 32'(out_valid), 32'd0);
      check("async_reset_data1", 32'(out_data_1), 32'd0);
`ifdef DEMUX_STATS_EN
      check("async_reset_count2", 32'(ch_count_2), 32'd0);
`endif
      tick();
      #2 rst_n = 1'b1;
      tick();
      send(2'd1, 5'd4);
      check("post_reset_valid", 32'(out_valid), 32'b0010);
      check("post_reset_data1", 32'(out_data_1), 32'd4);

`ifdef DEMUX_STATS_EN
      // 300 drains on ch3 saturate its counter at 255
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      tick();
      out_ready = 4'b1000;
      in_valid  = 1'b1;
      in_sel    = 2'd3;
      for (int i = 0; i < 300; i++) begin
         in_data = 5'(i);
         tick();
         if (i == 200) check("count3_at_200", 32'(ch_count_3), 32'd200);
      end
      in_valid = 1'b0;
      tick();
      check("count3_sat", 32'(ch_count_3), 32'd255);
      check("count0_zero", 32'(ch_count_0), 32'd0);
      check("count1_zero", 32'(ch_count_1), 32'd0);
      check("count2_zero", 32'(ch_count_2), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
